// File: rtl/nz_sel_gen.sv
// nz_sel_gen: select generator for a 17-to-1 zero-capable operand mux.
//
// Accepts one VEC_LEN-bit nonzero-lane mask per handshake and emits, one beat
// per transfer, the select codes of the set lanes in ascending order. An
// empty mask yields a single ZERO_SEL beat so the mux outputs zero.
//
// Optional build macro NZ_SEL_SKIP_EMPTY_EN: when defined, an all-zero mask is
// consumed without emitting any beat and the block stays/returns to idle.
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst_n      in   asynchronous active-low reset
//   mask_valid in   mask offered by upstream
//   mask_ready out  block can accept a mask this cycle
//   mask       in   nonzero lane mask, bit i = lane i
//   sel_valid  out  select beat valid
//   sel_ready  in   downstream accepts beat
//   sel        out  mux select code
//   sel_last   out  final beat of the current mask
//   sel_cnt    out  zero-based beat index within the current mask

module nz_sel_gen #(
   parameter int unsigned VEC_LEN   = 16,
   parameter int unsigned SEL_WIDTH = 5,
   parameter int unsigned ZERO_SEL  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mask_valid,
   output logic                 mask_ready,
   input  logic [VEC_LEN-1:0]   mask,
   output logic                 sel_valid,
   input  logic                 sel_ready,
   output logic [SEL_WIDTH-1:0] sel,
   output logic                 sel_last,
   output logic [SEL_WIDTH-1:0] sel_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   localparam logic [SEL_WIDTH-1:0] ZERO_CODE = SEL_WIDTH'(ZERO_SEL);
   localparam logic [VEC_LEN-1:0]   ONE_VEC   = {{(VEC_LEN-1){1'b0}}, 1'b1};

   logic [0:0]           state_q, state_d;
   logic [SEL_WIDTH-1:0] sel_q, sel_d;
   logic                 sel_last_q, sel_last_d;
   logic [SEL_WIDTH-1:0] sel_cnt_q, sel_cnt_d;
   logic [VEC_LEN-1:0]   rem_q, rem_d;

   logic mask_xfer;
   logic beat_xfer;

   // Lowest-set-bit index; ZERO_CODE when the vector is empty.
   function automatic logic [SEL_WIDTH-1:0] lsb_idx(input logic [VEC_LEN-1:0] v);
      logic [SEL_WIDTH-1:0] idx;
      idx = ZERO_CODE;
      for (int i = VEC_LEN - 1; i >= 0; i--) begin
         if (v[i]) idx = SEL_WIDTH'(i);
      end
      return idx;
   endfunction

   assign sel_valid  = (state_q == ST_EMIT);
   assign beat_xfer  = sel_valid && sel_ready;
   // Ready on the last accepted beat too, so masks stream without a bubble.
   assign mask_ready = (state_q == ST_IDLE) || (beat_xfer && sel_last_q);
   assign mask_xfer  = mask_valid && mask_ready;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      sel_last_d = sel_last_q;
      sel_cnt_d  = sel_cnt_q;
      rem_d      = rem_q;

      if (mask_xfer) begin
`ifdef NZ_SEL_SKIP_EMPTY_EN
         if (mask == '0) begin
            state_d    = ST_IDLE;
            sel_d      = ZERO_CODE;
            sel_last_d = 1'b0;
            sel_cnt_d  = '0;
            rem_d      = '0;
         end else
`endif
         begin
            // Empty mask falls out naturally: ZERO_CODE, rem 0, last 1.
            state_d    = ST_EMIT;
            sel_d      = lsb_idx(mask);
            rem_d      = mask & (mask - ONE_VEC);
            sel_last_d = (rem_d == '0);
            sel_cnt_d  = '0;
         end
      end else if (beat_xfer) begin
         if (sel_last_q) begin
            state_d    = ST_IDLE;
            sel_d      = ZERO_CODE;
            sel_last_d = 1'b0;
            sel_cnt_d  = '0;
            rem_d      = '0;
         end else begin
            sel_d      = lsb_idx(rem_q);
            rem_d      = rem_q & (rem_q - ONE_VEC);
            sel_last_d = (rem_d == '0);
            sel_cnt_d  = sel_cnt_q + SEL_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sel_q      <= ZERO_CODE;
         sel_last_q <= 1'b0;
         sel_cnt_q  <= '0;
         rem_q      <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         sel_last_q <= sel_last_d;
         sel_cnt_q  <= sel_cnt_d;
         rem_q      <= rem_d;
      end
   end

   assign sel      = sel_q;
   assign sel_last = sel_last_q;
   assign sel_cnt  = sel_cnt_q;

endmodule

// File: tb/tb_nz_sel_gen.sv
// Testbench for nz_sel_gen: directed and randomized masks; expected beats are
// queued on mask acceptance and checked by an independent monitor.

module tb_nz_sel_gen;

   typedef struct packed {
      logic [4:0] sel;
      logic [4:0] cnt;
      logic       last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mask_valid = 1'b0;
   logic        mask_ready;
   logic [15:0] mask = '0;
   logic        sel_valid;
   logic        sel_ready = 1'b0;
   logic [4:0]  sel;
   logic        sel_last;
   logic [4:0]  sel_cnt;

   int    checks = 0;
   int    errors = 0;
   beat_t sb[$];
   int    outstanding = 0;

   always #5 clk = ~clk;

   nz_sel_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mask_valid (mask_valid),
      .mask_ready (mask_ready),
      .mask       (mask),
      .sel_valid  (sel_valid),
      .sel_ready  (sel_ready),
      .sel        (sel),
      .sel_last   (sel_last),
      .sel_cnt    (sel_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: one beat per set lane, ascending; empty mask -> one zero beat.
   task automatic push_mask(input logic [15:0] m);
      int    n;
      beat_t b;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (m[i]) begin
            b.sel  = 5'(i);
            b.cnt  = 5'(n);
            b.last = 1'b0;
            sb.push_back(b);
            n++;
         end
      end
      if (n > 0) begin
         sb[sb.size() - 1].last = 1'b1;
      end else begin
`ifndef NZ_SEL_SKIP_EMPTY_EN
         b.sel  = 5'd16;
         b.cnt  = 5'd0;
         b.last = 1'b1;
         sb.push_back(b);
         n = 1;
`endif
      end
      outstanding += n;
   endtask

   // Drive one cycle of stimulus and predict handshake outcomes.
   task automatic cycle(input logic mv, input logic [15:0] m, input logic sr,
                        output logic acc);
      logic exp_ready;
      @(negedge clk);
      mask_valid = mv;
      mask       = m;
      sel_ready  = sr;
      #4;
      exp_ready = (outstanding == 0) || (outstanding == 1 && sr);
      chk("sel_valid", 32'(sel_valid), 32'(outstanding > 0));
      chk("mask_ready", 32'(mask_ready), 32'(exp_ready));
      if (outstanding > 0 && sr) outstanding--;
      acc = mv && exp_ready;
      if (acc) push_mask(m);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, " sel_valid"}, 32'(sel_valid), 32'd0);
      chk({tag, " sel"}, 32'(sel), 32'd16);
      chk({tag, " sel_last"}, 32'(sel_last), 32'd0);
      chk({tag, " sel_cnt"}, 32'(sel_cnt), 32'd0);
      chk({tag, " mask_ready"}, 32'(mask_ready), 32'd1);
   endtask

   function automatic logic [15:0] rand_mask();
      logic [15:0] r;
      case ($urandom_range(0, 5))
         0:       r = 16'h0000;
         1:       r = 16'hFFFF;
         2:       r = 16'h0001 << $urandom_range(0, 15);
         3:       r = 16'($urandom) & 16'($urandom);
         default: r = 16'($urandom);
      endcase
      return r;
   endfunction

   // Monitor: every valid beat must match the queue head and hold while stalled.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rst_n && sel_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected beat: got sel %0d expected no beat at %0t", sel, $time);
            end else begin
               chk("beat sel", 32'(sel), 32'(sb[0].sel));
               chk("beat sel_cnt", 32'(sel_cnt), 32'(sb[0].cnt));
               chk("beat sel_last", 32'(sel_last), 32'(sb[0].last));
               if (sel_ready) void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      logic        acc;
      logic [15:0] cur;

      // Reset held with random inputs.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mask_valid = 1'($urandom);
         mask       = 16'($urandom);
         sel_ready  = 1'($urandom);
         #1;
         reset_vals("reset");
      end
      @(negedge clk);
      mask_valid = 1'b0;
      sel_ready  = 1'b0;
      rst_n      = 1'b1;

      // Sparse mask, always ready.
      cycle(1'b1, 16'h8421, 1'b1, acc);
      repeat (5) cycle(1'b0, 16'h0, 1'b1, acc);

      // Full mask with ready toggling.
      cycle(1'b1, 16'hFFFF, 1'b0, acc);
      for (int i = 0; i < 34; i++) cycle(1'b0, 16'h0, 1'((i % 2) == 0), acc);

      // Empty mask.
      cycle(1'b1, 16'h0000, 1'b1, acc);
      repeat (3) cycle(1'b0, 16'h0, 1'b1, acc);

      // Back-to-back masks.
      cycle(1'b1, 16'h0003, 1'b1, acc);
      acc = 1'b0;
      for (int i = 0; i < 4 && !acc; i++) cycle(1'b1, 16'h0100, 1'b1, acc);
      chk("b2b accepted", 32'(acc), 32'd1);
      repeat (3) cycle(1'b0, 16'h0, 1'b1, acc);

      // Single-bit mask stalled; a competing mask must not be taken.
      cycle(1'b1, 16'h4000, 1'b0, acc);
      repeat (5) cycle(1'b1, 16'h0001, 1'b0, acc);
      repeat (3) cycle(1'b0, 16'h0, 1'b1, acc);

      // Asynchronous reset mid-emission.
      cycle(1'b1, 16'hFFFF, 1'b1, acc);
      repeat (3) cycle(1'b0, 16'h0, 1'b1, acc);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      reset_vals("async reset");
      sb.delete();
      outstanding = 0;
      mask_valid  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle(1'b0, 16'h0, 1'b1, acc);

      // Randomized traffic.
      cur = rand_mask();
      for (int i = 0; i < 800; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), cur, 1'($urandom_range(0, 3) != 0), acc);
         if (acc) cur = rand_mask();
      end

      // Drain with a bounded cycle budget.
      for (int i = 0; i < 40 && outstanding > 0; i++) cycle(1'b0, 16'h0, 1'b1, acc);
      chk("scoreboard drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
